// File: rtl/ahb_lite_arbiter.sv
// Round-robin AHB-Lite arbiter: NUM_MST masters share one slave port, ownership moves only after an accepted IDLE.
// Optional feature macro AHB_ARB_LOCK_EN: owner keeps the grant while it asserts HMASTLOCK.
module ahb_lite_arbiter #(
   parameter int NUM_MST = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
) (
   input  logic                       HCLK,
   input  logic                       HRESET,
   input  logic [NUM_MST*ADDR_W-1:0]  m_HADDR,
   input  logic [NUM_MST*2-1:0]       m_HTRANS,
   input  logic [NUM_MST-1:0]         m_HWRITE,
   input  logic [NUM_MST*3-1:0]       m_HSIZE,
   input  logic [NUM_MST*3-1:0]       m_HBURST,
   input  logic [NUM_MST*4-1:0]       m_HPROT,
   input  logic [NUM_MST-1:0]         m_HMASTLOCK,
   input  logic [NUM_MST*DATA_W-1:0]  m_HWDATA,
   output logic [NUM_MST-1:0]         m_HREADY,
   output logic [NUM_MST-1:0]         m_HRESP,
   output logic [DATA_W-1:0]          m_HRDATA,
   output logic [ADDR_W-1:0]          HADDR,
   output logic [1:0]                 HTRANS,
   output logic                       HWRITE,
   output logic [2:0]                 HSIZE,
   output logic [2:0]                 HBURST,
   output logic [3:0]                 HPROT,
   output logic                       HMASTLOCK,
   output logic [DATA_W-1:0]          HWDATA,
   output logic                       HSEL,
   output logic                       HREADY,
   input  logic                       HREADYOUT,
   input  logic                       HRESP,
   input  logic [DATA_W-1:0]          HRDATA,
   output logic [$clog2(NUM_MST)-1:0] HMASTER
);
   localparam int MW = $clog2(NUM_MST);
   localparam int unsigned N = NUM_MST;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_t;

   logic [MW-1:0]      down;
   logic [MW-1:0]      next_owner;
   logic [NUM_MST-1:0] req;
   htrans_t            owner_trans;
   logic               lock_held;
   logic               rel;
   logic               found;
   int unsigned        best_d;
   int unsigned        d;

   always_comb begin
      req = '0;
      for (int unsigned i = 0; i < N; i++) begin
         req[i] = m_HTRANS[2*i+1];
      end
   end

   assign owner_trans = htrans_t'(m_HTRANS[2*HMASTER +: 2]);

`ifdef AHB_ARB_LOCK_EN
   assign lock_held = m_HMASTLOCK[HMASTER];
   assign HMASTLOCK = ~HRESET & m_HMASTLOCK[HMASTER];
`else
   logic unused_lock;
   assign lock_held   = 1'b0;
   assign HMASTLOCK   = 1'b0;
   assign unused_lock = ^m_HMASTLOCK;
`endif

   assign rel = HREADYOUT & (owner_trans == IDLE) & ~lock_held;

   // Nearest requester above the owner (cyclic distance 1..N-1) wins.
   always_comb begin
      next_owner = HMASTER;
      found      = 1'b0;
      best_d     = N;
      d          = 0;
      for (int unsigned j = 0; j < N; j++) begin
         d = (j + N - 32'(HMASTER)) % N;
         if (req[j] && d != 0 && d < best_d) begin
            best_d     = d;
            next_owner = MW'(j);
            found      = 1'b1;
         end
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         HMASTER <= '0;
         down    <= '0;
      end else begin
         if (HREADYOUT) down <= HMASTER;
         if (rel && found) HMASTER <= next_owner;
      end
   end

   always_comb begin
      HADDR    = m_HADDR[HMASTER*ADDR_W +: ADDR_W];
      HTRANS   = HRESET ? IDLE : owner_trans;
      HWRITE   = m_HWRITE[HMASTER];
      HSIZE    = m_HSIZE[HMASTER*3 +: 3];
      HBURST   = m_HBURST[HMASTER*3 +: 3];
      HPROT    = m_HPROT[HMASTER*4 +: 4];
      HWDATA   = m_HWDATA[down*DATA_W +: DATA_W];
      HSEL     = ~HRESET;
      HREADY   = HREADYOUT;
      m_HRDATA = HRDATA;
   end

   // Non-owners stall only while they request; an idle non-owner sees ready.
   always_comb begin
      m_HREADY = '1;
      m_HRESP  = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (HRESET) begin
            m_HREADY[i] = 1'b1;
            m_HRESP[i]  = 1'b0;
         end else if (32'(HMASTER) == i) begin
            m_HREADY[i] = HREADYOUT;
            m_HRESP[i]  = HRESP;
         end else begin
            m_HREADY[i] = ~req[i];
            m_HRESP[i]  = 1'b0;
         end
      end
   end
endmodule
